// File: rtl/i2c_master.sv
// Single-register I2C master: one register write or read per start request.
// Open-drain SCL/SDA sequenced in quarter periods of CLK_DIV clocks, honours SCL stretching.
module i2c_master #(
  parameter int CLK_DIV = 16
) (
  input  logic       clk,
  input  logic       rstin,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] dev_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  inout  wire        scl_i2c,
  inout  wire        data_i2c
);
  localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [QW-1:0] Q_LAST = QW'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_AACK, S_REG, S_RACK, S_WDATA, S_WACK,
    S_RSTART, S_RADDR, S_RAACK, S_RDATA, S_MNACK, S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [1:0]    qtr_q, qtr_d;
  logic [2:0]    bit_q, bit_d;
  logic          rw_q, rw_d;
  logic [6:0]    dev_q, dev_d;
  logic [7:0]    reg_q, reg_d, wdat_q, wdat_d;
  logic [7:0]    rx_q, rx_d, rd_data_q, rd_data_d;
  logic          nack_q, nack_d, busy_q, busy_d, done_q, done_d, ack_err_q, ack_err_d;
  logic          scl_oe_q, scl_oe_d, sda_oe_q, sda_oe_d;
  logic [1:0]    meta_q, sync_q;
  logic          scl_s, sda_s;
  logic          is_bit, is_ack, phase_end;
  logic [1:0]    qtr_max;
  logic [7:0]    tx_byte;

  assign scl_i2c  = scl_oe_q ? 1'b0 : 1'bz;
  assign data_i2c = sda_oe_q ? 1'b0 : 1'bz;
  assign scl_s    = sync_q[1];
  assign sda_s    = sync_q[0];
  assign rd_data  = rd_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign ack_err  = ack_err_q;

  always_ff @(posedge clk) begin
    if (rstin) begin
      meta_q <= 2'b11;
      sync_q <= 2'b11;
    end else begin
      meta_q <= {scl_i2c, data_i2c};
      sync_q <= meta_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    qcnt_d    = qcnt_q;
    qtr_d     = qtr_q;
    bit_d     = bit_q;
    rw_d      = rw_q;
    dev_d     = dev_q;
    reg_d     = reg_q;
    wdat_d    = wdat_q;
    rx_d      = rx_q;
    rd_data_d = rd_data_q;
    nack_d    = nack_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ack_err_d = ack_err_q;
    scl_oe_d  = 1'b0;
    sda_oe_d  = 1'b0;
    phase_end = 1'b0;
    tx_byte   = 8'hFF;
    is_bit    = !(state_q inside {S_IDLE, S_START, S_RSTART, S_STOP});
    is_ack    = state_q inside {S_AACK, S_RACK, S_WACK, S_RAACK};
    qtr_max   = (state_q == S_START) ? 2'd1 :
                (state_q == S_RSTART || state_q == S_STOP) ? 2'd2 : 2'd3;

    if (state_q == S_IDLE) begin
      // busy stays high through the done cycle so a start there is not taken
      if (done_q) begin
        busy_d = 1'b0;
      end else if (start && !busy_q) begin
        state_d   = S_START;
        busy_d    = 1'b1;
        ack_err_d = 1'b0;
        nack_d    = 1'b0;
        rw_d      = rw;
        dev_d     = dev_addr;
        reg_d     = reg_addr;
        wdat_d    = wr_data;
        qcnt_d    = '0;
        qtr_d     = 2'd0;
        bit_d     = 3'd0;
      end
    end else begin
      if (qcnt_q != Q_LAST) begin
        qcnt_d = qcnt_q + QW'(1);
      end else if (!(is_bit && qtr_q == 2'd2 && !scl_s)) begin
        qcnt_d = '0;
        if (qtr_q != qtr_max) qtr_d = qtr_q + 2'd1;
        else begin
          qtr_d     = 2'd0;
          phase_end = 1'b1;
        end
      end
      if (is_bit && qtr_q == 2'd3 && qcnt_q == '0) begin
        if (is_ack) nack_d = sda_s;
        if (state_q == S_RDATA) rx_d = {rx_q[6:0], sda_s};
      end
      if (phase_end) begin
        case (state_q)
          S_START:  state_d = S_ADDR;
          S_ADDR, S_REG, S_WDATA, S_RADDR, S_RDATA: begin
            if (bit_q != 3'd7) bit_d = bit_q + 3'd1;
            else begin
              bit_d = 3'd0;
              case (state_q)
                S_ADDR:  state_d = S_AACK;
                S_REG:   state_d = S_RACK;
                S_WDATA: state_d = S_WACK;
                S_RADDR: state_d = S_RAACK;
                default: state_d = S_MNACK;
              endcase
            end
          end
          S_AACK:   state_d = nack_q ? S_STOP : S_REG;
          S_RACK:   state_d = nack_q ? S_STOP : (rw_q ? S_RSTART : S_WDATA);
          S_RSTART: state_d = S_RADDR;
          S_RAACK:  state_d = nack_q ? S_STOP : S_RDATA;
          S_STOP: begin
            state_d   = S_IDLE;
            done_d    = 1'b1;
            ack_err_d = nack_q;
            if (rw_q && !nack_q) rd_data_d = rx_q;
          end
          default:  state_d = S_STOP;
        endcase
      end
    end

    // line drives are derived from the next phase so they change with the phase registers
    case (state_d)
      S_ADDR:  tx_byte = {dev_q, 1'b0};
      S_REG:   tx_byte = reg_q;
      S_WDATA: tx_byte = wdat_q;
      S_RADDR: tx_byte = {dev_q, 1'b1};
      default: tx_byte = 8'hFF;
    endcase
    case (state_d)
      S_IDLE:   ;
      S_START:  sda_oe_d = (qtr_d == 2'd1);
      S_RSTART: begin
        scl_oe_d = (qtr_d == 2'd0);
        sda_oe_d = (qtr_d == 2'd2);
      end
      S_STOP: begin
        scl_oe_d = (qtr_d == 2'd0);
        sda_oe_d = (qtr_d != 2'd2);
      end
      default: begin
        scl_oe_d = !qtr_d[1];
        sda_oe_d = !tx_byte[~bit_d];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstin) begin
      state_q   <= S_IDLE;
      qcnt_q    <= '0;
      qtr_q     <= 2'd0;
      bit_q     <= 3'd0;
      rw_q      <= 1'b0;
      dev_q     <= 7'd0;
      reg_q     <= 8'd0;
      wdat_q    <= 8'd0;
      rx_q      <= 8'd0;
      rd_data_q <= 8'd0;
      nack_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      scl_oe_q  <= 1'b0;
      sda_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      qcnt_q    <= qcnt_d;
      qtr_q     <= qtr_d;
      bit_q     <= bit_d;
      rw_q      <= rw_d;
      dev_q     <= dev_d;
      reg_q     <= reg_d;
      wdat_q    <= wdat_d;
      rx_q      <= rx_d;
      rd_data_q <= rd_data_d;
      nack_q    <= nack_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
      scl_oe_q  <= scl_oe_d;
      sda_oe_q  <= sda_oe_d;
    end
  end
endmodule

// File: tb/tb_i2c_master.sv
// Bench for i2c_master: bus-level slave at address 0x46 plus a transaction-level reference
// (expected latency, ack_err, read data, bytes seen on the bus).
module tb_i2c_master;
  localparam int Q = 4;

  logic       clk = 1'b0, rstin = 1'b1, start = 1'b0, rw = 1'b0;
  logic [6:0] dev_addr = 7'd0;
  logic [7:0] reg_addr = 8'd0, wr_data = 8'd0;
  logic [7:0] rd_data;
  logic       busy, done, ack_err;
  wire        scl_w, sda_w;
  logic       slv_sda_low = 1'b0, hold_scl = 1'b0, s_reset = 1'b0;

  assign scl_w = hold_scl ? 1'b0 : 1'bz;
  assign sda_w = slv_sda_low ? 1'b0 : 1'bz;
  pullup (scl_w);
  pullup (sda_w);

  i2c_master #(.CLK_DIV(Q)) dut (
    .clk(clk), .rstin(rstin), .start(start), .rw(rw), .dev_addr(dev_addr),
    .reg_addr(reg_addr), .wr_data(wr_data), .rd_data(rd_data), .busy(busy),
    .done(done), .ack_err(ack_err), .scl_i2c(scl_w), .data_i2c(sda_w)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0, n_txn = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave model: samples the bus between clock edges, decodes START/STOP and bits from line changes
  logic       prev_scl = 1'b1, prev_sda = 1'b1;
  logic       s_active = 1'b0, s_rd = 1'b0, s_tx = 1'b0, s_mnack = 1'b0;
  int         s_bitn = 0, s_byte = 0;
  logic [7:0] s_rx = 8'd0, s_tx_byte = 8'd0, s_ptr = 8'd0;
  logic [7:0] s_mem [256];
  logic [7:0] exp_mem [256];
  logic [7:0] bus_log [$];
  logic [7:0] last_rd = 8'd0;

  always @(negedge clk) begin
    logic cs, cd;
    cs = scl_w;
    cd = sda_w;
    if (s_reset) begin
      s_active = 1'b0; s_tx = 1'b0; slv_sda_low = 1'b0;
    end else if (prev_scl && cs && prev_sda && !cd) begin
      s_active = 1'b1; s_bitn = 0; s_byte = 0; s_tx = 1'b0; slv_sda_low = 1'b0;
    end else if (prev_scl && cs && !prev_sda && cd) begin
      s_active = 1'b0; s_tx = 1'b0; slv_sda_low = 1'b0;
    end else if (s_active && !prev_scl && cs) begin
      if (s_bitn < 8) s_rx = {s_rx[6:0], cd};
      else s_mnack = cd;
      s_bitn++;
    end else if (s_active && prev_scl && !cs) begin
      if (s_bitn == 8) begin
        if (s_tx) slv_sda_low = 1'b0;
        else begin
          bus_log.push_back(s_rx);
          if (s_byte == 0) begin
            if (s_rx[7:1] == 7'h46) begin slv_sda_low = 1'b1; s_rd = s_rx[0]; end
            else s_active = 1'b0;
          end else if (s_byte == 1) begin
            s_ptr = s_rx; slv_sda_low = 1'b1;
          end else begin
            s_mem[s_ptr] = s_rx; s_ptr++; slv_sda_low = 1'b1;
          end
        end
      end else if (s_bitn == 9) begin
        s_bitn = 0; s_byte++; slv_sda_low = 1'b0;
        if (s_tx) begin
          if (s_mnack) s_tx = 1'b0;
          else begin s_ptr++; s_tx_byte = s_mem[s_ptr]; slv_sda_low = !s_tx_byte[7]; end
        end else if (s_byte == 1 && s_rd) begin
          s_tx = 1'b1; s_tx_byte = s_mem[s_ptr]; slv_sda_low = !s_tx_byte[7];
        end
      end else if (s_tx && s_bitn >= 1 && s_bitn <= 7) begin
        slv_sda_low = !s_tx_byte[7 - s_bitn];
      end
    end
    prev_scl = cs;
    prev_sda = cd;
  end

  // mode: 0 plain, 1 SCL stretch in ADDR bit 0, 2 stray start at cycle 100, 3 reset in REG byte
  task automatic txn(input logic r, input logic [6:0] d, input logic [7:0] ra,
                     input logic [7:0] wd, input int mode);
    int cyc, exp_cyc, exp_n, wait_n;
    logic seen, ok;
    logic [23:0] exp_bytes, got_bytes;
    logic [7:0] exp_rd;
    bus_log.delete();
    wait_n = 0;
    while (busy && wait_n < 2000) begin @(posedge clk); #1; wait_n++; end
    rw = r; dev_addr = d; reg_addr = ra; wr_data = wd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_accept", busy, 1'b1);
    check("ack_err_cleared", ack_err, 1'b0);
    if (mode == 3) begin
      repeat (50 * Q) @(posedge clk);
      #1 rstin = 1'b1;
      @(posedge clk); #1;
      check("rst_scl_released", scl_w, 1'b1);
      check("rst_sda_released", sda_w, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_rd_data", rd_data, 8'h00);
      s_reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 rstin = 1'b0; s_reset = 1'b0;
      seen = 1'b0;
      repeat (150 * Q) begin @(posedge clk); #1; if (done) seen = 1'b1; end
      check("no_done_after_reset", seen, 1'b0);
      last_rd = 8'h00;
      n_txn++;
      $display("txn %0d: reset mid-REG rw=%0d dev=%02h reg=%02h", n_txn, r, d, ra);
      return;
    end
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 200 * Q) begin
      @(posedge clk); #1; cyc++;
      // released 8 cycles past the normal Q2 end; the 2-flop synchroniser adds 2 -> 10 extra
      if (mode == 1 && cyc == 4 * Q) hold_scl = 1'b1;
      if (mode == 1 && cyc == 5 * Q + 7) hold_scl = 1'b0;
      if (mode == 2 && cyc == 100) begin
        start = 1'b1; rw = ~r; dev_addr = 7'h12; reg_addr = ~ra; wr_data = ~wd;
      end
      if (mode == 2 && cyc == 101) start = 1'b0;
      if (done) seen = 1'b1;
    end
    ok = (d == 7'h46);
    exp_cyc = (!ok ? 41 * Q : (r ? 152 * Q : 113 * Q)) + (mode == 1 ? 10 : 0);
    exp_rd = (r && ok) ? exp_mem[ra] : last_rd;
    if (!ok) begin exp_bytes = {16'h0, d, 1'b0}; exp_n = 1; end
    else if (r) begin exp_bytes = {d, 1'b0, ra, d, 1'b1}; exp_n = 3; end
    else begin exp_bytes = {d, 1'b0, ra, wd}; exp_n = 3; exp_mem[ra] = wd; end
    check("done_latency", cyc, exp_cyc);
    check("ack_err", ack_err, !ok);
    check("rd_data", rd_data, exp_rd);
    last_rd = exp_rd;
    got_bytes = 24'h0;
    foreach (bus_log[i]) if (i < 3) got_bytes = {got_bytes[15:0], bus_log[i]};
    check("bus_bytes", got_bytes, exp_bytes);
    check("bus_byte_count", bus_log.size(), exp_n);
    if (!r && ok) check("slave_reg", s_mem[ra], wd);
    @(posedge clk); #1;
    check("done_one_cycle", done, 1'b0);
    check("busy_released", busy, 1'b0);
    if (mode == 2) begin
      seen = 1'b0;
      repeat (130 * Q) begin @(posedge clk); #1; if (done || busy) seen = 1'b1; end
      check("stray_start_ignored", seen, 1'b0);
    end
    n_txn++;
    $display("txn %0d: rw=%0d dev=%02h reg=%02h wd=%02h mode=%0d cycles=%0d ack_err=%0d rd=%02h",
             n_txn, r, d, ra, wd, mode, cyc, ack_err, rd_data);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] rd_dev;
    for (int i = 0; i < 256; i++) begin
      s_mem[i] = 8'($urandom);
      exp_mem[i] = s_mem[i];
    end
    s_mem[2] = 8'h80;
    exp_mem[2] = 8'h80;
    repeat (4) @(posedge clk);
    #1;
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_ack_err", ack_err, 1'b0);
    check("reset_rd_data", rd_data, 8'h00);
    check("reset_scl", scl_w, 1'b1);
    check("reset_sda", sda_w, 1'b1);
    rstin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    txn(1'b0, 7'h46, 8'h08, 8'h31, 0);
    txn(1'b0, 7'h47, 8'h08, 8'h55, 0);
    txn(1'b1, 7'h46, 8'h02, 8'h00, 0);
    txn(1'b0, 7'h46, 8'h10, 8'hA5, 1);
    txn(1'b1, 7'h46, 8'h10, 8'h00, 1);
    txn(1'b0, 7'h46, 8'h20, 8'h5A, 2);
    txn(1'b0, 7'h46, 8'h30, 8'h77, 3);
    txn(1'b1, 7'h46, 8'h08, 8'h00, 0);
    for (int k = 0; k < 12; k++) begin
      rd_dev = 7'h46;
      if ($urandom_range(3) == 0) begin
        rd_dev = 7'($urandom);
        if (rd_dev == 7'h46) rd_dev = 7'h47;
      end
      txn(1'($urandom), rd_dev, 8'($urandom), 8'($urandom), 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
